// File: rtl/btn_control.sv
// Push-button front end: two-flop synchroniser, counter debouncer, press-edge
// detector and a wrapping 3-bit selector advanced once per debounced press.
module btn_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned NUM_SEL         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic [2:0] sel
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    SEL_MAX = 3'(NUM_SEL - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_d;
  logic          press;
  logic [CW-1:0] cnt;

  assign press = db & ~db_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_d <= 1'b0;
      cnt  <= '0;
      sel  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      db_d <= db;

      // db only follows s2 after it has disagreed for DEBOUNCE_CYCLES edges in a row
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (press) begin
        sel <= (sel == SEL_MAX) ? 3'd0 : sel + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_btn_control.sv
// Self-checking bench for btn_control: default instance (NUM_SEL=8) and a
// NUM_SEL=5 instance share clock, reset and button stimulus.
module tb_btn_control;

  logic       clk;
  logic       reset;
  logic       btn;
  logic [2:0] sel8;
  logic [2:0] sel5;

  int total = 0;
  int bad   = 0;

  btn_control #(.DEBOUNCE_CYCLES(2), .NUM_SEL(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .sel  (sel8)
  );

  btn_control #(.DEBOUNCE_CYCLES(2), .NUM_SEL(5)) dut5 (
    .clk  (clk),
    .reset(reset),
    .btn  (btn),
    .sel  (sel5)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       b;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic [2:0] e);
    vec_t v;
    v.rst = r;
    v.b   = b;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic b);
    @(negedge clk);
    reset = r;
    btn   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int unsigned hold, input int unsigned rel);
    for (int unsigned i = 0; i < hold; i++) step(1'b0, 1'b1);
    for (int unsigned i = 0; i < rel; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    btn   = 1'b0;

    // Reset with unknown/high button, then release with button low.
    add(1'b1, 1'bx, 3'd0);
    add(1'b1, 1'b1, 3'd0);
    add(1'b0, 1'b0, 3'd0);
    add(1'b0, 1'b0, 3'd0);
    // Press sampled first at vector 4; sel must move exactly at vector 8.
    for (int i = 4; i <= 7; i++) add(1'b0, 1'b1, 3'd0);
    add(1'b0, 1'b1, 3'd1);
    add(1'b0, 1'b1, 3'd1);
    for (int i = 10; i <= 14; i++) add(1'b0, 1'b0, 3'd1);
    // One-cycle glitch is rejected.
    add(1'b0, 1'b1, 3'd1);
    for (int i = 16; i <= 19; i++) add(1'b0, 1'b0, 3'd1);
    // Three-cycle press is accepted; increment lands at vector 24.
    for (int i = 20; i <= 22; i++) add(1'b0, 1'b1, 3'd1);
    add(1'b0, 1'b0, 3'd1);
    for (int i = 24; i <= 27; i++) add(1'b0, 1'b0, 3'd2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].b);
      check($sformatf("vec%0d_sel8", i), sel8, vecs[i].exp);
      check($sformatf("vec%0d_sel5", i), sel5, vecs[i].exp);
    end

    // Wrap-around: 8 clean presses from reset.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("wrap_reset_sel8", sel8, 3'd0);
    check("wrap_reset_sel5", sel5, 3'd0);
    for (int unsigned p = 1; p <= 8; p++) begin
      press(6, 6);
      check($sformatf("wrap%0d_sel8", p), sel8, 3'(p % 8));
      check($sformatf("wrap%0d_sel5", p), sel5, 3'(p % 5));
    end
    // sel8=0, sel5=3 here.

    // Reset between db rising and sel updating discards the pending press.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("midrst_pre_sel8", sel8, 3'd0);
    check("midrst_pre_sel5", sel5, 3'd3);
    step(1'b1, 1'b1);
    check("midrst_sel8", sel8, 3'd0);
    check("midrst_sel5", sel5, 3'd0);
    // Held button after reset is a fresh press with full latency.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("postrst_lat_sel8", sel8, 3'd0);
    check("postrst_lat_sel5", sel5, 3'd0);
    step(1'b0, 1'b1);
    check("postrst_inc_sel8", sel8, 3'd1);
    check("postrst_inc_sel5", sel5, 3'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    check("postrst_hold_sel8", sel8, 3'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    check("postrst_rel_sel8", sel8, 3'd1);

    // Periodic toggling every 100 time units, offset away from clock edges.
    @(negedge clk);
    #5;
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      #100;
      btn = 1'b0;
      #100;
    end
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    check("toggle_sel8", sel8, 3'd7);
    check("toggle_sel5", sel5, 3'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
